// File: rtl/ib_activity_detect.sv
// rtl/ib_activity_detect.sv - instrument-bus activity detector: sync, glitch filter, edge pulses, handshake FSM
// Produces one-cycle registered trigger pulses for the LED pulse-stretch stage.
module ib_activity_detect #(
  parameter int FILT_CYCLES  = 4,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic dav_n,
  input  logic nrfd_n,
  input  logic ndac_n,
  input  logic atn_n,
  input  logic srq_n,
  input  logic ren_n,
  input  logic ifc_n,
  output logic data_pulse,
  output logic cmd_pulse,
  output logic atn_pulse,
  output logic srq_pulse,
  output logic ren_pulse,
  output logic ifc_pulse,
  output logic to_pulse
);

  localparam int NL = 7;
  localparam int L_DAV  = 0;
  localparam int L_NDAC = 2;
  localparam int L_ATN  = 3;
  localparam int L_SRQ  = 4;
  localparam int L_REN  = 5;
  localparam int L_IFC  = 6;
  localparam logic [3:0] FILT_N = 4'(FILT_CYCLES);
  localparam logic [TIMEOUT_BITS-1:0] STALL_MAX = '1;

  typedef enum logic [1:0] {IDLE, DAV_LOW, ACCEPTED, STALL} state_t;

  logic [NL-1:0] raw;
  logic [NL-1:0] s1_q, s2_q;
  logic [NL-1:0] filt_q, filt_d;
  logic [NL-1:0] filt_prev_q;
  logic [3:0]    fcnt_q [NL];
  logic [3:0]    fcnt_d [NL];
  logic [NL-1:0] fall;

  state_t                  state_q;
  logic [TIMEOUT_BITS-1:0] stall_q;
  logic                    atn_cap_q;
  logic data_q, cmd_q, to_q;
  logic atn_p_q, srq_p_q, ren_p_q, ifc_p_q;

  logic dav, ndac, atn;
  logic unused_lines;

  assign raw = {ifc_n, ren_n, srq_n, atn_n, ndac_n, nrfd_n, dav_n};

  // A level only follows the synchronized line after FILT_CYCLES consecutive differing edges.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < NL; i++) begin
      if (s2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] + 4'd1 == FILT_N) begin
          filt_d[i] = s2_q[i];
          fcnt_d[i] = 4'd0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end else begin
        fcnt_d[i] = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '1;
      s2_q        <= '1;
      filt_q      <= '1;
      filt_prev_q <= '1;
      for (int i = 0; i < NL; i++) fcnt_q[i] <= 4'd0;
    end else begin
      s1_q        <= raw;
      s2_q        <= s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
    end
  end

  assign fall = filt_prev_q & ~filt_q;
  assign dav  = filt_q[L_DAV];
  assign ndac = filt_q[L_NDAC];
  assign atn  = filt_q[L_ATN];
  // nrfd plays no part in completion; dav/nrfd/ndac edges do not drive pulses.
  assign unused_lines = ^{fall[2:0], filt_q[1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      atn_p_q <= 1'b0;
      srq_p_q <= 1'b0;
      ren_p_q <= 1'b0;
      ifc_p_q <= 1'b0;
    end else begin
      atn_p_q <= fall[L_ATN];
      srq_p_q <= fall[L_SRQ];
      ren_p_q <= fall[L_REN];
      ifc_p_q <= fall[L_IFC];
    end
  end

  // Interface clear wins over any completion or timeout decided on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      stall_q   <= '0;
      atn_cap_q <= 1'b1;
      data_q    <= 1'b0;
      cmd_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      data_q <= 1'b0;
      cmd_q  <= 1'b0;
      to_q   <= 1'b0;
      if (fall[L_IFC]) begin
        state_q <= IDLE;
        stall_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            stall_q <= '0;
            if (!dav) begin
              state_q   <= DAV_LOW;
              atn_cap_q <= atn;
            end
          end
          DAV_LOW: begin
            if (stall_q == STALL_MAX) begin
              to_q    <= 1'b1;
              state_q <= STALL;
              stall_q <= '0;
            end else if (dav) begin
              state_q <= IDLE;
              stall_q <= '0;
            end else if (ndac) begin
              state_q <= ACCEPTED;
              stall_q <= '0;
            end else begin
              stall_q <= stall_q + 1'b1;
            end
          end
          ACCEPTED: begin
            if (stall_q == STALL_MAX) begin
              to_q    <= 1'b1;
              state_q <= STALL;
              stall_q <= '0;
            end else if (dav) begin
              state_q <= IDLE;
              stall_q <= '0;
              cmd_q   <= ~atn_cap_q;
              data_q  <= atn_cap_q;
            end else begin
              stall_q <= stall_q + 1'b1;
            end
          end
          STALL: begin
            stall_q <= '0;
            if (dav) state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            stall_q <= '0;
          end
        endcase
      end
    end
  end

  assign data_pulse = data_q;
  assign cmd_pulse  = cmd_q;
  assign atn_pulse  = atn_p_q;
  assign srq_pulse  = srq_p_q;
  assign ren_pulse  = ren_p_q;
  assign ifc_pulse  = ifc_p_q;
  assign to_pulse   = to_q;

endmodule

// File: doc/ib_activity_detect.md
IB_ACTIVITY_DETECT -- requirements
Module: ib_activity_detect

Interface
REQ-001 Parameter FILT_CYCLES, default 4, range 1..15: consecutive cycles a synchronized line must hold a new level before the filtered level follows.
REQ-002 Parameter TIMEOUT_BITS, default 16: width of the handshake stall counter; the timeout limit is 2^TIMEOUT_BITS-1 cycles.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, synchronous to clk, active-high.
REQ-005 dav_n, nrfd_n, ndac_n, atn_n, srq_n, ren_n, ifc_n  input  1 each  raw instrument-bus lines, asynchronous to clk, active-low.
REQ-006 data_pulse  output  1  one-cycle high: data byte transfer completed.
REQ-007 cmd_pulse  output  1  one-cycle high: command byte transfer completed (ATN asserted at DAV assertion).
REQ-008 atn_pulse, srq_pulse, ren_pulse, ifc_pulse  output  1 each  one-cycle high on the filtered assertion (high-to-low) edge of that line.
REQ-009 to_pulse  output  1  one-cycle high: handshake stall timeout.
REQ-010 All outputs SHALL be registered, active-high, synchronous to clk, suitable as the trigger input of the LED pulse-stretch stage.

Function
REQ-011 Each raw line SHALL pass through a two-flop synchronizer; the synchronizer flops reset to 1 (inactive).
REQ-012 Per line, a filter counter SHALL count clock edges at which the synchronized value differs from the filtered level; the counter clears to 0 at any edge where they are equal.
REQ-013 The filtered level SHALL take the synchronized value at the edge where the count of consecutive differing edges reaches FILT_CYCLES; the counter then clears.
REQ-014 A synchronized pulse shorter than FILT_CYCLES cycles SHALL leave the filtered level and all outputs unchanged.
REQ-015 Latency: raw change first sampled at edge 0 -> filtered level changes at edge FILT_CYCLES+1 -> edge pulse high for exactly one cycle after edge FILT_CYCLES+2.
REQ-016 atn/srq/ren/ifc_pulse SHALL fire only on filtered 1->0 transitions; deassertion edges produce no pulse.
REQ-017 Handshake FSM states: IDLE, DAV_LOW, ACCEPTED, STALL; all transitions use filtered levels.
REQ-018 IDLE -> DAV_LOW when dav is low; at this transition the FSM SHALL capture the filtered atn level as the byte type.
REQ-019 DAV_LOW -> ACCEPTED when ndac is high; nrfd is ignored.
REQ-020 ACCEPTED -> IDLE when dav is high, issuing cmd_pulse if the captured atn was low, otherwise data_pulse (never both).
REQ-021 DAV_LOW -> IDLE without a pulse if dav returns high before ndac goes high (aborted transfer).
REQ-022 Stall counter: increments each cycle in DAV_LOW or ACCEPTED, clears on every state change and in IDLE/STALL; it SHALL NOT wrap.
REQ-023 When the stall counter equals 2^TIMEOUT_BITS-1 in DAV_LOW or ACCEPTED, the FSM SHALL issue to_pulse and enter STALL; STALL -> IDLE when dav is high, with no transfer pulse.
REQ-024 A filtered ifc 1->0 transition SHALL force the FSM to IDLE and clear the stall counter in the same edge; it overrides a simultaneous transfer completion or timeout (no data/cmd/to pulse that cycle).
REQ-025 Independent edge pulses SHALL be able to fire in the same cycle as each other and as FSM pulses.
REQ-026 A line held low through reset release SHALL produce its assertion pulse FILT_CYCLES+3 edges after rst deasserts, i.e. it is treated as a fresh assertion.

Reset
REQ-027 While rst is high: all outputs 0, synchronizers and filtered levels 1, filter and stall counters 0, FSM IDLE, captured atn 1.
REQ-028 Reset asserted mid-transfer SHALL discard the transfer with no pulse.

Verification
REQ-029 Data byte: dav_n low, then ndac_n high after 10 cycles, then dav_n high with atn_n high -> one data_pulse, no cmd_pulse, at FILT_CYCLES+2 edges after the dav_n rise is sampled.
REQ-030 Command byte: atn_n low before dav_n falls, full handshake -> atn_pulse once, then exactly one cmd_pulse.
REQ-031 Glitch: srq_n low for FILT_CYCLES-1 cycles, then low for FILT_CYCLES cycles -> no pulse for the first, one srq_pulse for the second.
REQ-032 Timeout (TIMEOUT_BITS=4): dav_n low, ndac_n held low -> to_pulse after 15 DAV_LOW cycles; dav_n high -> IDLE, no data_pulse.
REQ-033 IFC priority: ifc_n filtered fall in the same cycle as dav_n filtered rise in ACCEPTED -> ifc_pulse only, FSM IDLE.
REQ-034 Reset mid-transfer in ACCEPTED -> all outputs 0; after release with lines idle, no pulses.
